lsu_dm: RTL

Load/store unit sitting directly upstream of the word-only data memory DM (word-addressed, synchronous write on clk when we=1, combinational read). It accepts RV32I memory-stage requests (LB/LH/LW/LBU/LHU/SB/SH/SW) and translates them into DM word accesses:
- sub-word stores become a same-cycle read-modify-write;
- loads are byte/halfword extracted and extended.

It flags misaligned or illegal accesses instead of touching DM.

---
 rtl/lsu_pkg.sv | 44 ++++
 rtl/lsu_dm_lane_align.sv | 68 ++++++
 rtl/lsu_dm.sv | 110 +++++++++++
 3 files changed

// File: rtl/lsu_pkg.sv
//------------------------------------------------------------------------------
// lsu_pkg: shared funct3 codes, FSM states and byte-lane tables for lsu_dm.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_e;

  // Byte enables per lane, indexed by addr[1:0] (byte) or addr[1] (half).
  localparam logic [3:0][3:0] BYTE_BE = {4'b1000, 4'b0100, 4'b0010, 4'b0001};
  localparam logic [1:0][3:0] HALF_BE = {4'b1100, 4'b0011};
  localparam logic [3:0]      WORD_BE = 4'b1111;

  function automatic logic lsu_req_legal(input logic       we,
                                         input logic [2:0] funct3,
                                         input logic [1:0] off);
    logic ok;
    ok = 1'b0;
    case (funct3)
      F3_B:  ok = 1'b1;
      F3_H:  ok = ~off[0];
      F3_W:  ok = (off == 2'b00);
      F3_BU: ok = ~we;
      F3_HU: ok = ~we & ~off[0];
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

`default_nettype wire

// File: rtl/lsu_dm_lane_align.sv
//------------------------------------------------------------------------------
// lsu_lane_align: combinational store-lane merge and load extract/extend.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [31:0] dm_rd_i,
  input  logic [31:0] wdata_i,
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  off_i,
  output logic [31:0] wd_o,
  output logic [31:0] rdata_o
);

  logic [3:0]  be;
  logic [31:0] wrep;
  logic [7:0]  lbyte;
  logic [15:0] lhalf;

  always_comb begin
    be   = 4'b0000;
    wrep = wdata_i;
    case (funct3_i[1:0])
      2'b00: begin
        be   = BYTE_BE[off_i];
        wrep = {4{wdata_i[7:0]}};
      end
      2'b01: begin
        be   = HALF_BE[off_i[1]];
        wrep = {2{wdata_i[15:0]}};
      end
      2'b10: begin
        be   = WORD_BE;
        wrep = wdata_i;
      end
      default: begin
        be   = 4'b0000;
        wrep = wdata_i;
      end
    endcase
  end

  // Replicated store data lands in every lane; the enables pick which lanes win.
  for (genvar i = 0; i < 4; i++) begin : g_byte
    assign wd_o[8*i +: 8] = be[i] ? wrep[8*i +: 8] : dm_rd_i[8*i +: 8];
  end

  assign lbyte = dm_rd_i[8*off_i +: 8];
  assign lhalf = off_i[1] ? dm_rd_i[31:16] : dm_rd_i[15:0];

  always_comb begin
    rdata_o = 32'h0;
    case (funct3_i)
      F3_B:    rdata_o = {{24{lbyte[7]}}, lbyte};
      F3_H:    rdata_o = {{16{lhalf[15]}}, lhalf};
      F3_W:    rdata_o = dm_rd_i;
      F3_BU:   rdata_o = {24'h0, lbyte};
      F3_HU:   rdata_o = {16'h0, lhalf};
      default: rdata_o = 32'h0;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/lsu_dm.sv
//------------------------------------------------------------------------------
// lsu_dm: RV32I load/store unit in front of a word-only data memory.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module lsu_dm
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 16
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              req_we_i,
  input  logic [2:0]        req_funct3_i,
  input  logic [31:0]       req_addr_i,
  input  logic [31:0]       req_wdata_i,
  output logic              resp_valid_o,
  output logic [31:0]       resp_rdata_o,
  output logic              resp_err_o,
  output logic              dm_we_o,
  output logic [ADDR_W-1:0] dm_addr_o,
  output logic [31:0]       dm_wd_o,
  input  logic [31:0]       dm_rd_i
);

  state_e            state_q;
  logic [ADDR_W+1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [2:0]        funct3_q;
  logic              we_q;
  logic [31:0]       resp_rdata_q;
  logic              resp_err_q;

  logic              accept;
  logic              req_legal;
  logic              in_access;
  logic [31:0]       merged_wd;
  logic [31:0]       load_rdata;

  if (ADDR_W < 30) begin : g_unused
    logic addr_hi_unused;
    assign addr_hi_unused = ^req_addr_i[31:ADDR_W+2];
  end

  assign in_access   = (state_q == ACCESS);
  assign req_ready_o = ~in_access;
  assign accept      = req_valid_i & req_ready_o;
  assign req_legal   = lsu_req_legal(req_we_i, req_funct3_i, req_addr_i[1:0]);

  lsu_lane_align u_align (
    .dm_rd_i  (dm_rd_i),
    .wdata_i  (wdata_q),
    .funct3_i (funct3_q),
    .off_i    (addr_q[1:0]),
    .wd_o     (merged_wd),
    .rdata_o  (load_rdata)
  );

  // Write strobe is decoded from state so an async reset kills it at once.
  assign dm_we_o      = in_access & we_q;
  assign dm_wd_o      = dm_we_o ? merged_wd : 32'h0;
  assign dm_addr_o    = addr_q[ADDR_W+1:2];
  assign resp_valid_o = (state_q == RESP);
  assign resp_rdata_o = resp_rdata_q;
  assign resp_err_o   = resp_err_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      wdata_q      <= 32'h0;
      funct3_q     <= 3'b000;
      we_q         <= 1'b0;
      resp_rdata_q <= 32'h0;
      resp_err_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE, RESP: begin
          if (accept) begin
            addr_q   <= req_addr_i[ADDR_W+1:0];
            wdata_q  <= req_wdata_i;
            funct3_q <= req_funct3_i;
            we_q     <= req_we_i;
            if (req_legal) begin
              state_q <= ACCESS;
            end else begin
              state_q      <= RESP;
              resp_rdata_q <= 32'h0;
              resp_err_q   <= 1'b1;
            end
          end else begin
            state_q <= IDLE;
          end
        end
        ACCESS: begin
          state_q      <= RESP;
          resp_rdata_q <= we_q ? 32'h0 : load_rdata;
          resp_err_q   <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire
